dmem_arbiter_ctrl: RTL and testbench
====================================

// Module: dmem_arbiter_ctrl
// PURPOSE
//  Shares the single-port synchronous data memory between the CPU pipeline
//  (VLD/VSD memory ops from the decode/EX path) and the NIC.
//  CPU has default priority. A NIC starvation counter forces one NIC grant
//  after STARVE_LIM lost cycles. Drives the memory port from registers and
//  steers returned read data back to the requester that issued the read.
// PARAMETERS
//  DATA_W     64  memory word width (bits)
//  ADDR_W     16  memory address width (matches 16-bit imm_addr)
//  STARVE_LIM 4   consecutive NIC-lost cycles before NIC is forced; legal 1..15
// PORTS
//  clk         in   1       clock; all logic on posedge
//  reset_n     in   1       asynchronous active-low reset
//  cpu_memEn   in   1       CPU memory request; held until cpu_stall==0
//  cpu_memwrEn in   1       CPU write (1) / read (0); valid with cpu_memEn
//  cpu_addr    in   ADDR_W  CPU address, [0:ADDR_W-1]
//  cpu_wdata   in   DATA_W  CPU store data
//  cpu_stall   out  1       comb: cpu_memEn & ~cpu_grant
//  cpu_rvalid  out  1       CPU read data valid (1-cycle pulse)
//  cpu_rdata   out  DATA_W  = mem_rdata (pass-through)
//  nic_req     in   1       NIC request; held until nic_gnt
//  nic_wr      in   1       NIC write (1) / read (0)
//  nic_addr    in   ADDR_W  NIC address
//  nic_wdata   in   DATA_W  NIC write data
//  nic_gnt     out  1       comb: NIC request accepted this cycle
//  nic_rvalid  out  1       NIC read data valid (1-cycle pulse)
//  nic_rdata   out  DATA_W  = mem_rdata (pass-through)
//  mem_en      out  1       registered memory enable
//  mem_wrEn    out  1       registered write enable
//  mem_addr    out  ADDR_W  registered address
//  mem_wdata   out  DATA_W  registered write data
//  mem_rdata   in   DATA_W  memory read data, valid cycle after mem_en&~mem_wrEn
// BEHAVIOUR
//  Grant (comb, cycle T): state==NIC_PRIO & nic_req -> NIC;
//    else cpu_memEn -> CPU; else nic_req -> NIC; else none. One grant max.
//  Port stage: winner's en/wr/addr/wdata registered -> mem_* in T+1;
//    no grant -> mem_en=0, mem_wrEn=0; mem_addr/mem_wdata hold last value.
//  Read return: 2-bit owner tag {none,cpu,nic} registered with mem_* for
//    reads; delayed one more cycle; cpu_rvalid/nic_rvalid high in T+2.
//    Writes never produce rvalid. Fully pipelined: one access per cycle.
//  Starvation FSM, states NORMAL / NIC_PRIO, wait_cnt 4 bits:
//    NORMAL: nic_req & ~nic_gnt -> wait_cnt+1; reaching STARVE_LIM -> NIC_PRIO.
//      nic_gnt or ~nic_req -> wait_cnt=0.
//    NIC_PRIO: NIC wins over CPU (CPU stalls). nic_gnt -> NORMAL, wait_cnt=0.
//      nic_req dropped (protocol violation) -> NORMAL, wait_cnt=0.
//  Simultaneous cpu_memEn & nic_req in NORMAL: CPU wins, wait_cnt increments.
//  Continuous contention, STARVE_LIM=N: N CPU grants, 1 NIC grant, repeat.
//  Reset (async, any cycle): state=NORMAL, wait_cnt=0, mem_en=0, mem_wrEn=0,
//    mem_addr=0, mem_wdata=0, tags=none, cpu_rvalid=0, nic_rvalid=0.
//    In-flight reads dropped; no rvalid after reset release.
//  cpu_stall, nic_gnt comb; 0 while reset_n=0.
// CONFIGURATION
//  DMEM_ARB_STATS_EN defined: adds outputs cpu_stall_cnt[0:31] and
//    nic_force_cnt[0:31]. Increment on each cpu_stall cycle / each
//    NIC_PRIO grant. Saturate at all-ones; reset to 0.
//  Undefined: ports and counters absent; arbitration identical.
// TESTING
//  CPU read 0x0010 alone, mem_rdata=64'hDEADBEEF_00000001 -> cpu_stall=0;
//    T+1 mem_en=1,wrEn=0,addr=0x0010; T+2 cpu_rvalid=1 with that data, nic_rvalid=0.
//  NIC write 0x0100 data 0x55.. alone -> nic_gnt=1 in T; T+1 mem_wrEn=1,
//    addr=0x0100; no rvalid.
//  cpu_memEn, nic_req held 12 cycles, STARVE_LIM=4 -> NIC granted cycles 5, 10;
//    cpu_stall=1 only those cycles.
//  CPU read A in T, NIC read B in T+1 -> cpu_rvalid T+2, nic_rvalid T+3;
//    each rdata matches its address.
//  reset_n low in T+1 of a CPU read -> no cpu_rvalid; all outputs at reset
//    values; FSM NORMAL.
//  DMEM_ARB_STATS_EN, contention test above -> cpu_stall_cnt=2, nic_force_cnt=2.

Source files
------------

// File: rtl/dmem_arbiter_ctrl.sv
// dmem_arbiter_ctrl: shares the single-port data memory between the CPU pipeline and the NIC,
// with a NIC starvation guard. Define DMEM_ARB_STATS_EN to add stall / forced-grant counters.
module dmem_arbiter_ctrl #(
   parameter int unsigned DATA_W     = 64,
   parameter int unsigned ADDR_W     = 16,
   parameter int unsigned STARVE_LIM = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              cpu_memEn,
   input  logic              cpu_memwrEn,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_stall,
   output logic              cpu_rvalid,
   output logic [DATA_W-1:0] cpu_rdata,
   input  logic              nic_req,
   input  logic              nic_wr,
   input  logic [ADDR_W-1:0] nic_addr,
   input  logic [DATA_W-1:0] nic_wdata,
   output logic              nic_gnt,
   output logic              nic_rvalid,
   output logic [DATA_W-1:0] nic_rdata,
   output logic              mem_en,
   output logic              mem_wrEn,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
`ifdef DMEM_ARB_STATS_EN
  ,output logic [31:0]       cpu_stall_cnt,
   output logic [31:0]       nic_force_cnt
`endif
);

   localparam int unsigned CNT_W = 4;
   localparam logic [CNT_W-1:0] LIM_M1 = CNT_W'(STARVE_LIM - 1);

   typedef enum logic {NORMAL, NIC_PRIO} state_t;
   typedef enum logic [1:0] {TAG_NONE, TAG_CPU, TAG_NIC} tag_t;

   state_t           state;
   logic [CNT_W-1:0] wait_cnt;
   tag_t             tag;
   logic             cpu_win;
   logic             nic_win;

   // Grant: forced NIC first, then CPU, then NIC; nothing granted while in reset
   always_comb begin
      cpu_win = 1'b0;
      nic_win = 1'b0;
      if (reset_n) begin
         if (state == NIC_PRIO && nic_req) nic_win = 1'b1;
         else if (cpu_memEn)               cpu_win = 1'b1;
         else if (nic_req)                 nic_win = 1'b1;
      end
   end

   assign cpu_stall = reset_n & cpu_memEn & ~cpu_win;
   assign nic_gnt   = nic_win;
   assign cpu_rdata = mem_rdata;
   assign nic_rdata = mem_rdata;

   // Starvation tracking: count cycles the NIC waits, force one grant at the limit
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= NORMAL;
         wait_cnt <= '0;
      end else begin
         case (state)
            NORMAL: begin
               if (nic_req && !nic_win) begin
                  wait_cnt <= wait_cnt + CNT_W'(1);
                  if (wait_cnt == LIM_M1) state <= NIC_PRIO;
               end else begin
                  wait_cnt <= '0;
               end
            end
            default: begin
               // granted, or request withdrawn: either way back to normal priority
               if (nic_win || !nic_req) begin
                  state    <= NORMAL;
                  wait_cnt <= '0;
               end
            end
         endcase
      end
   end

   // Memory port stage plus read-owner tag
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mem_en    <= 1'b0;
         mem_wrEn  <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         tag       <= TAG_NONE;
      end else begin
         mem_en <= cpu_win | nic_win;
         if (cpu_win) begin
            mem_wrEn  <= cpu_memwrEn;
            mem_addr  <= cpu_addr;
            mem_wdata <= cpu_wdata;
            tag       <= cpu_memwrEn ? TAG_NONE : TAG_CPU;
         end else if (nic_win) begin
            mem_wrEn  <= nic_wr;
            mem_addr  <= nic_addr;
            mem_wdata <= nic_wdata;
            tag       <= nic_wr ? TAG_NONE : TAG_NIC;
         end else begin
            mem_wrEn  <= 1'b0;
            tag       <= TAG_NONE;
         end
      end
   end

   // Read data arrives the cycle after the port stage; steer valid to its owner
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cpu_rvalid <= 1'b0;
         nic_rvalid <= 1'b0;
      end else begin
         cpu_rvalid <= (tag == TAG_CPU);
         nic_rvalid <= (tag == TAG_NIC);
      end
   end

`ifdef DMEM_ARB_STATS_EN
   // Saturating event counters
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cpu_stall_cnt <= '0;
         nic_force_cnt <= '0;
      end else begin
         if (cpu_stall && cpu_stall_cnt != '1)
            cpu_stall_cnt <= cpu_stall_cnt + 32'd1;
         if (nic_win && state == NIC_PRIO && nic_force_cnt != '1)
            nic_force_cnt <= nic_force_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_dmem_arbiter_ctrl.sv
// tb_dmem_arbiter_ctrl: randomized bench with reference arbiter, memory model and
// scoreboard queues drained by a monitor on the falling edge.
module tb_dmem_arbiter_ctrl;

   localparam int unsigned DATA_W = 64;
   localparam int unsigned ADDR_W = 16;
   localparam int unsigned LIM    = 4;

   logic              clk = 1'b0;
   logic              reset_n = 1'b0;
   logic              cpu_memEn = 1'b0, cpu_memwrEn = 1'b0;
   logic [ADDR_W-1:0] cpu_addr = '0;
   logic [DATA_W-1:0] cpu_wdata = '0;
   logic              cpu_stall, cpu_rvalid;
   logic [DATA_W-1:0] cpu_rdata;
   logic              nic_req = 1'b0, nic_wr = 1'b0;
   logic [ADDR_W-1:0] nic_addr = '0;
   logic [DATA_W-1:0] nic_wdata = '0;
   logic              nic_gnt, nic_rvalid;
   logic [DATA_W-1:0] nic_rdata;
   logic              mem_en, mem_wrEn;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata = '0;
`ifdef DMEM_ARB_STATS_EN
   logic [31:0]       cpu_stall_cnt, nic_force_cnt;
`endif

   dmem_arbiter_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .STARVE_LIM(LIM)) dut (
      .clk(clk), .reset_n(reset_n),
      .cpu_memEn(cpu_memEn), .cpu_memwrEn(cpu_memwrEn), .cpu_addr(cpu_addr),
      .cpu_wdata(cpu_wdata), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid),
      .cpu_rdata(cpu_rdata),
      .nic_req(nic_req), .nic_wr(nic_wr), .nic_addr(nic_addr), .nic_wdata(nic_wdata),
      .nic_gnt(nic_gnt), .nic_rvalid(nic_rvalid), .nic_rdata(nic_rdata),
      .mem_en(mem_en), .mem_wrEn(mem_wrEn), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef DMEM_ARB_STATS_EN
     ,.cpu_stall_cnt(cpu_stall_cnt), .nic_force_cnt(nic_force_cnt)
`endif
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int passed = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
   endtask

   // Memory contents: synchronous single-port RAM driven by the DUT port
   logic [DATA_W-1:0] mem     [0:65535];
   logic [DATA_W-1:0] ref_mem [0:65535];

   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_wrEn) mem[mem_addr] <= mem_wdata;
         else          mem_rdata     <= mem[mem_addr];
      end
   end

   typedef struct {
      int unsigned       cyc;
      logic              wr;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } port_t;
   typedef struct {
      int unsigned       cyc;
      logic              nic;
      logic [DATA_W-1:0] data;
   } rsp_t;

   port_t pq[$];
   rsp_t  rq[$];
   port_t mp;
   rsp_t  mr;

   // Reference arbiter: cycles the NIC has been refused in a row
   int lost = 0;

   // One cycle of stimulus; returns model winner (0 none, 1 cpu, 2 nic) and observed nic_gnt
   task automatic step(input bit ce, input bit cw, input logic [ADDR_W-1:0] ca,
                       input logic [DATA_W-1:0] cd,
                       input bit ne, input bit nw, input logic [ADDR_W-1:0] na,
                       input logic [DATA_W-1:0] nd,
                       output int w, output bit got_nic);
      logic              wr;
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] d;
      cpu_memEn = ce; cpu_memwrEn = cw; cpu_addr = ca; cpu_wdata = cd;
      nic_req = ne;   nic_wr = nw;      nic_addr = na; nic_wdata = nd;
      #1;
      if (ne && lost >= int'(LIM)) w = 2;
      else if (ce)                 w = 1;
      else if (ne)                 w = 2;
      else                         w = 0;
      chk("cpu_stall", 64'(cpu_stall), 64'(ce && w != 1));
      chk("nic_gnt",   64'(nic_gnt),   64'(w == 2));
      got_nic = nic_gnt;
      if (w != 0) begin
         wr = (w == 1) ? cw : nw;
         a  = (w == 1) ? ca : na;
         d  = (w == 1) ? cd : nd;
         pq.push_back('{cyc + 1, wr, a, d});
         if (wr) ref_mem[a] = d;
         else    rq.push_back('{cyc + 2, (w == 2), ref_mem[a]});
      end
      if (ne && w != 2) lost++;
      else              lost = 0;
      @(posedge clk); #1;
   endtask

   task automatic idle(input int n);
      int w;
      bit g;
      for (int i = 0; i < n; i++) step(0, 0, '0, '0, 0, 0, '0, '0, w, g);
   endtask

   task automatic chk_reset_outputs();
      chk("rst_mem_en",     64'(mem_en),     64'(0));
      chk("rst_mem_wrEn",   64'(mem_wrEn),   64'(0));
      chk("rst_mem_addr",   64'(mem_addr),   64'(0));
      chk("rst_mem_wdata",  mem_wdata,       64'(0));
      chk("rst_cpu_rvalid", 64'(cpu_rvalid), 64'(0));
      chk("rst_nic_rvalid", 64'(nic_rvalid), 64'(0));
      chk("rst_cpu_stall",  64'(cpu_stall),  64'(0));
      chk("rst_nic_gnt",    64'(nic_gnt),    64'(0));
   endtask

   // Monitor: compares port activity and read returns against the scoreboard
   always @(negedge clk) begin
      if (reset_n) begin
         if (pq.size() != 0 && pq[0].cyc == cyc) begin
            mp = pq.pop_front();
            chk("mem_en",    64'(mem_en),   64'(1));
            chk("mem_wrEn",  64'(mem_wrEn), 64'(mp.wr));
            chk("mem_addr",  64'(mem_addr), 64'(mp.addr));
            chk("mem_wdata", mem_wdata,     mp.wdata);
         end else begin
            chk("mem_idle_en",   64'(mem_en),   64'(0));
            chk("mem_idle_wrEn", 64'(mem_wrEn), 64'(0));
         end
         if (rq.size() != 0 && rq[0].cyc == cyc) begin
            mr = rq.pop_front();
            chk("cpu_rvalid", 64'(cpu_rvalid), 64'(!mr.nic));
            chk("nic_rvalid", 64'(nic_rvalid), 64'(mr.nic));
            chk("rdata", mr.nic ? nic_rdata : cpu_rdata, mr.data);
         end else begin
            chk("idle_cpu_rvalid", 64'(cpu_rvalid), 64'(0));
            chk("idle_nic_rvalid", 64'(nic_rvalid), 64'(0));
         end
      end
   end

   initial begin
      int w;
      bit g;
      bit nic_seen [1:12];
      bit cp, np, cw, nw;
      logic [ADDR_W-1:0] ca, na;
      logic [DATA_W-1:0] cd, nd;

      for (int i = 0; i < 65536; i++) begin
         mem[i] = {16'(i), 16'hA5A5, ~16'(i), 16'(i * 7)};
      end
      mem[16'h0010] = 64'hDEADBEEF_00000001;
      for (int i = 0; i < 65536; i++) ref_mem[i] = mem[i];

      // Reset with both requesters asserting: no grants, reset values everywhere
      cpu_memEn = 1'b1; nic_req = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk_reset_outputs();
      cpu_memEn = 1'b0; nic_req = 1'b0;
      reset_n = 1'b1;

      // Lone CPU read, lone NIC write
      step(1, 0, 16'h0010, '0, 0, 0, '0, '0, w, g);
      idle(3);
      step(0, 0, '0, '0, 1, 1, 16'h0100, 64'h5555_5555_5555_5555, w, g);
      idle(3);

      // Continuous contention: NIC forced in cycles 5 and 10
      for (int i = 1; i <= 12; i++) begin
         step(1, 0, 16'h0020, '0, 1, 0, 16'h0030, '0, w, g);
         nic_seen[i] = g;
      end
      for (int i = 1; i <= 12; i++)
         chk($sformatf("contention_gnt_c%0d", i), 64'(nic_seen[i]), 64'(i == 5 || i == 10));
`ifdef DMEM_ARB_STATS_EN
      chk("cpu_stall_cnt", 64'(cpu_stall_cnt), 64'(2));
      chk("nic_force_cnt", 64'(nic_force_cnt), 64'(2));
`endif
      idle(3);

      // Back-to-back reads from different owners
      step(1, 0, 16'h0041, '0, 0, 0, '0, '0, w, g);
      step(0, 0, '0, '0, 1, 0, 16'h0042, '0, w, g);
      idle(3);

      // Reset in the cycle after a CPU read: the read must vanish
      step(1, 0, 16'h0010, '0, 0, 0, '0, '0, w, g);
      cpu_memEn = 1'b1; nic_req = 1'b1;
      reset_n = 1'b0;
      #1;
      chk_reset_outputs();
      pq.delete();
      rq.delete();
      lost = 0;
      @(posedge clk); #1;
      chk("rst_hold_cpu_rvalid", 64'(cpu_rvalid), 64'(0));
      @(posedge clk); #1;
      cpu_memEn = 1'b0; nic_req = 1'b0;
      reset_n = 1'b1;
      idle(3);
      // Fresh arbitration: CPU wins the first contended cycle
      step(1, 0, 16'h0007, '0, 1, 0, 16'h0008, '0, w, g);
      chk("post_reset_nic_gnt", 64'(g), 64'(0));
      step(0, 0, '0, '0, 1, 0, 16'h0008, '0, w, g);
      idle(3);

      // Randomized traffic honouring the hold protocols
      cp = 0; np = 0; cw = 0; nw = 0; ca = '0; na = '0; cd = '0; nd = '0;
      for (int i = 0; i < 1500; i++) begin
         if (!cp && $urandom_range(0, 99) < 60) begin
            cp = 1;
            cw = ($urandom_range(0, 2) == 0);
            ca = 16'($urandom_range(0, 31));
            cd = {$urandom, $urandom};
         end
         if (!np && $urandom_range(0, 99) < 50) begin
            np = 1;
            nw = ($urandom_range(0, 2) == 0);
            na = 16'($urandom_range(0, 31));
            nd = {$urandom, $urandom};
         end
         step(cp, cw, ca, cd, np, nw, na, nd, w, g);
         if (w == 1) cp = 0;
         if (w == 2) np = 0;
      end
      idle(4);

      chk("drain_port", 64'(pq.size()), 64'(0));
      chk("drain_rsp",  64'(rq.size()), 64'(0));

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
